// File: rtl/main_fsm_pkg.sv
// Shared control definitions for the multicycle main FSM: state encodings,
// datapath select codes and ALU cmd constants.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_MULEX    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] SRCA_REG = 2'd0;
  localparam logic [1:0] SRCA_PC  = 2'd1;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;

  // Commands whose carry/overflow flags are meaningful.
  function automatic logic is_arith(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP) || (cmd == CMD_CMN);
  endfunction

  function automatic logic is_cmp(input logic [3:0] cmd);
    return (cmd == CMD_CMP) || (cmd == CMD_CMN);
  endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// Combinational state-to-output decode for main_fsm; all outputs forced to 0 when out_en is low.
// The MULEX decode exists only when MUL_SEQ_EN is defined.
module fsm_outdec
  import main_fsm_pkg::*;
(
  input  logic       out_en,
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       cond_ex,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic       mul_first,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       alu_op,
  output logic       mul_start,
  output logic [1:0] flag_write
);

  logic [3:0] cmd;
  logic       set_flags;
  assign cmd       = funct[4:1];
  assign set_flags = funct[0] & cond_ex;

`ifndef MUL_SEQ_EN
  logic unused_mul_first;
  assign unused_mul_first = mul_first;
`endif

  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = SRCA_REG;
    alu_src_b  = SRCB_REG;
    result_src = RES_ALUOUT;
    alu_op     = 1'b0;
    mul_start  = 1'b0;
    flag_write = 2'b00;
    if (out_en) begin
      case (state_e'(state))
        S_FETCH: begin
          alu_src_a  = SRCA_PC;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a  = SRCA_PC;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
        end
        S_EXECR, S_EXECI: begin
          alu_src_b  = (state_e'(state) == S_EXECI) ? SRCB_IMM : SRCB_REG;
          alu_op     = 1'b1;
          flag_write = {set_flags, set_flags & is_arith(cmd)};
        end
        S_ALUWB: begin
          reg_write = cond_ex & ~is_cmp(cmd);
          pc_write  = cond_ex & ~is_cmp(cmd) & (rd == 4'd15);
        end
        S_MEMADR: alu_src_b = SRCB_IMM;
        S_MEMREAD: adr_src = 1'b1;
        S_MEMWB: begin
          result_src = RES_MEM;
          reg_write  = cond_ex;
          pc_write   = cond_ex & (rd == 4'd15);
        end
        S_MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = cond_ex;
        end
        S_BRANCH: begin
          alu_src_b  = SRCB_IMM;
          result_src = RES_ALU;
          pc_write   = cond_ex;
        end
`ifdef MUL_SEQ_EN
        S_MULEX: mul_start = mul_first;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle processor main control FSM; next-state logic and multiply counter live here.
// Optional multi-cycle multiply sequencing is enabled by defining MUL_SEQ_EN.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       IsMul,
  input  logic       CondEx,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       MulStart,
  output logic [1:0] FlagWrite,
  output logic [3:0] State
);

  state_e state_q, state_d;
  logic   mul_first;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

`ifdef MUL_SEQ_EN
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

  // The load value is only ever seen on the first MULEX cycle.
  assign mul_first = (state_q == S_MULEX) && (cnt_q == MUL_LOAD);
`else
  logic unused_is_mul;
  assign unused_is_mul = IsMul;
  assign mul_first     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
`ifdef MUL_SEQ_EN
    cnt_d = cnt_q;
`endif
    case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM: state_d = S_MEMADR;
          OP_DP: begin
`ifdef MUL_SEQ_EN
            if (IsMul) begin
              state_d = S_MULEX;
              cnt_d   = MUL_LOAD;
            end else
`endif
            if (Funct[5]) state_d = S_EXECI;
            else          state_d = S_EXECR;
          end
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_ALUWB:          state_d = S_FETCH;
      S_MEMADR:         state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:        if (MemReady) state_d = S_MEMWB;
      S_MEMWB:          state_d = S_FETCH;
      // A store that fails its condition has nothing to wait for.
      S_MEMWRITE:       if (MemReady || !CondEx) state_d = S_FETCH;
      S_BRANCH:         state_d = S_FETCH;
`ifdef MUL_SEQ_EN
      S_MULEX: begin
        if (cnt_q == 4'd0) state_d = S_ALUWB;
        else               cnt_d   = cnt_q - 4'd1;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  assign State = state_q;

  fsm_outdec u_outdec (
    .out_en     (reset),
    .state      (state_q),
    .mem_ready  (MemReady),
    .cond_ex    (CondEx),
    .funct      (Funct),
    .rd         (Rd),
    .mul_first  (mul_first),
    .ir_write   (IRWrite),
    .pc_write   (PCWrite),
    .reg_write  (RegWrite),
    .mem_write  (MemWrite),
    .adr_src    (AdrSrc),
    .alu_src_a  (ALUSrcA),
    .alu_src_b  (ALUSrcB),
    .result_src (ResultSrc),
    .alu_op     (ALUOp),
    .mul_start  (MulStart),
    .flag_write (FlagWrite)
  );

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: each driven cycle pushes its expected state/output,
// a negedge monitor pops and compares.
module tb_main_fsm;
  import main_fsm_pkg::*;

  localparam int MC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       is_mul, cond_ex, mem_ready;
  logic       IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, ALUOp, MulStart;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, FlagWrite;
  logic [3:0] State;
  logic [14:0] all_outs;

  int n_chk  = 0;
  int n_pass = 0;

  typedef enum {SIG_NONE, SIG_IRW, SIG_PCW, SIG_REGW, SIG_MEMW, SIG_FLAGW, SIG_MULST, SIG_ALLW} sig_e;
  typedef struct {
    string      tag;
    logic [3:0] st;
    sig_e       sig;
    logic [3:0] val;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  main_fsm #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .Op(op), .Funct(funct), .Rd(rd), .IsMul(is_mul),
    .CondEx(cond_ex), .MemReady(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .MulStart(MulStart),
    .FlagWrite(FlagWrite), .State(State)
  );

  assign all_outs = {IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
                     ResultSrc, ALUOp, MulStart, FlagWrite};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [3:0] get_sig(input sig_e s);
    case (s)
      SIG_IRW:   return {3'd0, IRWrite};
      SIG_PCW:   return {3'd0, PCWrite};
      SIG_REGW:  return {3'd0, RegWrite};
      SIG_MEMW:  return {3'd0, MemWrite};
      SIG_FLAGW: return {2'd0, FlagWrite};
      SIG_MULST: return {3'd0, MulStart};
      SIG_ALLW:  return {IRWrite | PCWrite, RegWrite, MemWrite, |FlagWrite};
      default:   return 4'd0;
    endcase
  endfunction

  // Called at a negedge with inputs already set for this cycle; returns at the next negedge.
  task automatic cyc(input string tag, input state_e st, input sig_e sig, input logic [3:0] val);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    #2;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk({mon_e.tag, "_state"}, {12'd0, State}, {12'd0, mon_e.st});
      if (mon_e.sig != SIG_NONE)
        chk(mon_e.tag, {12'd0, get_sig(mon_e.sig)}, {12'd0, mon_e.val});
    end
  end

  task automatic set_in(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                        input logic m, input logic ce, input logic mr);
    op = o; funct = f; rd = r; is_mul = m; cond_ex = ce; mem_ready = mr;
  endtask

  initial begin
    reset = 1'b0;
    set_in(2'b00, 6'b101001, 4'd1, 1'b0, 1'b1, 1'b1);
    #2;
    // FETCH would raise IRWrite with MemReady=1 if reset did not gate outputs.
    chk("rst_outs", {1'b0, all_outs}, 16'd0);
    chk("rst_state", {12'd0, State}, {12'd0, S_FETCH});
    @(negedge clk);
    reset = 1'b1;

    // ADD immediate with S: FETCH, DECODE, EXECI, ALUWB.
    cyc("add_fetch", S_FETCH, SIG_IRW, 4'd1);
    cyc("add_dec", S_DECODE, SIG_ALLW, 4'd0);
    cyc("add_execi", S_EXECI, SIG_FLAGW, 4'd3);
    cyc("add_aluwb", S_ALUWB, SIG_REGW, 4'd1);

    // Undefined op returns to FETCH with no writes.
    set_in(2'b11, 6'b000000, 4'd1, 1'b0, 1'b1, 1'b1);
    cyc("undef_fetch", S_FETCH, SIG_IRW, 4'd1);
    cyc("undef_dec", S_DECODE, SIG_ALLW, 4'd0);

    // LDR, memory stalls three cycles in MEMREAD.
    set_in(2'b01, 6'b000001, 4'd2, 1'b0, 1'b1, 1'b1);
    cyc("ldr_fetch", S_FETCH, SIG_IRW, 4'd1);
    cyc("ldr_dec", S_DECODE, SIG_NONE, 4'd0);
    mem_ready = 1'b0;
    cyc("ldr_adr", S_MEMADR, SIG_ALLW, 4'd0);
    for (int i = 0; i < 3; i++) cyc($sformatf("ldr_wait%0d", i), S_MEMREAD, SIG_REGW, 4'd0);
    mem_ready = 1'b1;
    cyc("ldr_rd_done", S_MEMREAD, SIG_REGW, 4'd0);
    cyc("ldr_wb", S_MEMWB, SIG_REGW, 4'd1);

    // STR failing its condition: DECODE is cycle 1, FETCH is cycle 4.
    set_in(2'b01, 6'b000000, 4'd3, 1'b0, 1'b0, 1'b1);
    cyc("strn_fetch", S_FETCH, SIG_IRW, 4'd1);
    cyc("strn_dec", S_DECODE, SIG_NONE, 4'd0);
    mem_ready = 1'b0;
    cyc("strn_adr", S_MEMADR, SIG_MEMW, 4'd0);
    cyc("strn_memw", S_MEMWRITE, SIG_MEMW, 4'd0);
    cyc("strn_refetch", S_FETCH, SIG_IRW, 4'd0);

    // STR passing its condition, two stall cycles.
    set_in(2'b01, 6'b000000, 4'd3, 1'b0, 1'b1, 1'b1);
    cyc("str_fetch", S_FETCH, SIG_IRW, 4'd1);
    cyc("str_dec", S_DECODE, SIG_NONE, 4'd0);
    mem_ready = 1'b0;
    cyc("str_adr", S_MEMADR, SIG_NONE, 4'd0);
    cyc("str_w0", S_MEMWRITE, SIG_MEMW, 4'd1);
    cyc("str_w1", S_MEMWRITE, SIG_MEMW, 4'd1);
    mem_ready = 1'b1;
    cyc("str_w2", S_MEMWRITE, SIG_MEMW, 4'd1);

    // Taken branch.
    set_in(2'b10, 6'b000000, 4'd0, 1'b0, 1'b1, 1'b1);
    cyc("b_fetch", S_FETCH, SIG_IRW, 4'd1);
    cyc("b_dec", S_DECODE, SIG_NONE, 4'd0);
    cyc("b_branch", S_BRANCH, SIG_PCW, 4'd1);

    // CMP register: both flags written, no register write.
    set_in(2'b00, 6'b010101, 4'd4, 1'b0, 1'b1, 1'b1);
    cyc("cmp_fetch", S_FETCH, SIG_IRW, 4'd1);
    cyc("cmp_dec", S_DECODE, SIG_NONE, 4'd0);
    cyc("cmp_execr", S_EXECR, SIG_FLAGW, 4'd3);
    cyc("cmp_aluwb", S_ALUWB, SIG_REGW, 4'd0);

    // AND with S: only the NZ flag group is written.
    set_in(2'b00, 6'b000001, 4'd5, 1'b0, 1'b1, 1'b1);
    cyc("and_fetch", S_FETCH, SIG_IRW, 4'd1);
    cyc("and_dec", S_DECODE, SIG_NONE, 4'd0);
    cyc("and_execr", S_EXECR, SIG_FLAGW, 4'd2);
    cyc("and_aluwb", S_ALUWB, SIG_PCW, 4'd0);

    // SUB immediate into R15, no S: PC is written from ALUWB.
    set_in(2'b00, 6'b100100, 4'd15, 1'b0, 1'b1, 1'b1);
    cyc("subpc_fetch", S_FETCH, SIG_IRW, 4'd1);
    cyc("subpc_dec", S_DECODE, SIG_NONE, 4'd0);
    cyc("subpc_execi", S_EXECI, SIG_FLAGW, 4'd0);
    cyc("subpc_aluwb", S_ALUWB, SIG_PCW, 4'd1);

    // Multiply request.
    set_in(2'b00, 6'b000000, 4'd6, 1'b1, 1'b1, 1'b1);
    cyc("mul_fetch", S_FETCH, SIG_IRW, 4'd1);
    cyc("mul_dec", S_DECODE, SIG_NONE, 4'd0);
`ifdef MUL_SEQ_EN
    for (int i = 0; i < MC; i++)
      cyc($sformatf("mul_ex%0d", i), S_MULEX, SIG_MULST, (i == 0) ? 4'd1 : 4'd0);
    cyc("mul_aluwb", S_ALUWB, SIG_REGW, 4'd1);
`else
    cyc("mul_ignored", S_EXECR, SIG_MULST, 4'd0);
    cyc("mul_aluwb", S_ALUWB, SIG_REGW, 4'd1);
`endif

    // Reset asserted mid-MEMWRITE.
    set_in(2'b01, 6'b000000, 4'd3, 1'b0, 1'b1, 1'b1);
    cyc("rstw_fetch", S_FETCH, SIG_IRW, 4'd1);
    cyc("rstw_dec", S_DECODE, SIG_NONE, 4'd0);
    mem_ready = 1'b0;
    cyc("rstw_adr", S_MEMADR, SIG_NONE, 4'd0);
    cyc("rstw_w0", S_MEMWRITE, SIG_MEMW, 4'd1);
    #2;
    chk("rstw_pre_memw", {15'd0, MemWrite}, 16'd1);
    #1 reset = 1'b0;
    #1;
    chk("rstw_async_memw", {15'd0, MemWrite}, 16'd0);
    chk("rstw_async_state", {12'd0, State}, {12'd0, S_FETCH});
    @(negedge clk);
    chk("rstw_hold_outs", {1'b0, all_outs}, 16'd0);
    reset = 1'b1;
    cyc("rstw_rel_fetch", S_FETCH, SIG_IRW, 4'd0);
    mem_ready = 1'b1;
    cyc("rstw_rel_fetch2", S_FETCH, SIG_IRW, 4'd1);
    cyc("rstw_rel_dec", S_DECODE, SIG_NONE, 4'd0);

    #3;
    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
